// File: rtl/tile_puzzle_ctrl.sv
// tile_puzzle_ctrl
// Sliding-tile puzzle game controller for the VGA tile renderer. It holds a
// ROWS x COLS board as a packed tile-index bus. The blank is moved by
// debounced direction buttons or by an LFSR-driven shuffle sequence. A
// saturating move counter and registered solved detection are also provided.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_dir      direction levels [0]=up [1]=down [2]=left [3]=right (async)
//   btn_shuffle  shuffle request level (async)
//   tiles        packed board, cell i at [i*IDX_W +: IDX_W], 0 = blank
//   blank_pos    cell index of the blank
//   move_count   valid player moves since reset or last shuffle (saturating)
//   solved       board equals home arrangement (registered)
//   busy         shuffle in progress
//
// Optional feature macro: WIN_LOCK_EN
//   When WIN_LOCK_EN is defined, a player move that solves the board enters a
//   WIN state. In WIN, direction requests are ignored until a shuffle or reset.

module tile_puzzle_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int IDX_W         = 3,
  parameter int CNT_W         = 16,
  parameter int SHUFFLE_STEPS = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        btn_dir,
  input  logic                              btn_shuffle,
  output logic [ROWS*COLS*IDX_W-1:0]        tiles,
  output logic [$clog2(ROWS*COLS)-1:0]      blank_pos,
  output logic [CNT_W-1:0]                  move_count,
  output logic                              solved,
  output logic                              busy
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SHUFFLE_STEPS + 1);

  typedef enum logic [1:0] {IDLE, SHUFFLE, WIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] cells      [N];
  logic [IDX_W-1:0] next_cells [N];
  logic [RW-1:0]    blank_row;
  logic [CW-1:0]    blank_col;
  logic [SW-1:0]    steps;
  logic [15:0]      lfsr;
  logic             fb;
  logic [4:0]       btn_all;
  logic [4:0]       s1, s2, s3;
  logic [4:0]       pulse;
  logic             move_req;
  logic [1:0]       move_dir;
  logic             move_ok;
  logic [PW-1:0]    nb_pos;
  logic [RW-1:0]    nb_row;
  logic [CW-1:0]    nb_col;
  logic             cur_is_home;

  function automatic logic [IDX_W-1:0] home_val(input int i);
    return (i == N - 1) ? '0 : IDX_W'(i + 1);
  endfunction

  assign btn_all = {btn_shuffle, btn_dir};
  assign pulse   = s2 & ~s3;
  assign fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tiles[i*IDX_W +: IDX_W] = cells[i];
    end
  end

  // Pick the requested direction. A shuffle pulse in IDLE swallows any
  // direction pulse of the same cycle. Only the highest-priority pulse is
  // considered, even if that move turns out to be off the board.
  always_comb begin
    move_req = 1'b0;
    move_dir = 2'd0;
    if (state == SHUFFLE) begin
      move_req = 1'b1;
      move_dir = lfsr[1:0];
    end else if (state == IDLE && !pulse[4]) begin
      if (pulse[0]) begin
        move_req = 1'b1;
        move_dir = 2'd0;
      end else if (pulse[1]) begin
        move_req = 1'b1;
        move_dir = 2'd1;
      end else if (pulse[2]) begin
        move_req = 1'b1;
        move_dir = 2'd2;
      end else if (pulse[3]) begin
        move_req = 1'b1;
        move_dir = 2'd3;
      end
    end
  end

  // Row/column of the blank are tracked alongside blank_pos so that the
  // edge checks need no division.
  always_comb begin
    move_ok = 1'b0;
    nb_pos  = blank_pos;
    nb_row  = blank_row;
    nb_col  = blank_col;
    case (move_dir)
      2'd0: if (blank_row != '0) begin
        move_ok = move_req;
        nb_pos  = blank_pos - PW'(COLS);
        nb_row  = blank_row - RW'(1);
      end
      2'd1: if (blank_row != RW'(ROWS - 1)) begin
        move_ok = move_req;
        nb_pos  = blank_pos + PW'(COLS);
        nb_row  = blank_row + RW'(1);
      end
      2'd2: if (blank_col != '0) begin
        move_ok = move_req;
        nb_pos  = blank_pos - PW'(1);
        nb_col  = blank_col - CW'(1);
      end
      default: if (blank_col != CW'(COLS - 1)) begin
        move_ok = move_req;
        nb_pos  = blank_pos + PW'(1);
        nb_col  = blank_col + CW'(1);
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      next_cells[i] = cells[i];
    end
    if (move_ok) begin
      next_cells[blank_pos] = cells[nb_pos];
      next_cells[nb_pos]    = '0;
    end
  end

  always_comb begin
    cur_is_home = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (cells[i] != home_val(i)) cur_is_home = 1'b0;
    end
  end

`ifdef WIN_LOCK_EN
  logic next_is_home;

  // Look at the board as it will be after this edge, so the move that
  // solves the puzzle can enter WIN at the same edge.
  always_comb begin
    next_is_home = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (next_cells[i] != home_val(i)) next_is_home = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cells[i] <= home_val(i);
      end
      blank_pos  <= PW'(N - 1);
      blank_row  <= RW'(ROWS - 1);
      blank_col  <= CW'(COLS - 1);
      move_count <= '0;
      solved     <= 1'b1;
      busy       <= 1'b0;
      state      <= IDLE;
      steps      <= '0;
      lfsr       <= 16'hACE1;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
    end else begin
      lfsr   <= {fb, lfsr[15:1]};
      s1     <= btn_all;
      s2     <= s1;
      s3     <= s2;
      solved <= cur_is_home;
      for (int i = 0; i < N; i++) begin
        cells[i] <= next_cells[i];
      end
      if (move_ok) begin
        blank_pos <= nb_pos;
        blank_row <= nb_row;
        blank_col <= nb_col;
      end
      case (state)
        IDLE, WIN: begin
          if (pulse[4]) begin
            state      <= SHUFFLE;
            steps      <= SW'(SHUFFLE_STEPS);
            move_count <= '0;
            busy       <= 1'b1;
          end else if (move_ok) begin
            if (move_count != '1) move_count <= move_count + CNT_W'(1);
`ifdef WIN_LOCK_EN
            if (next_is_home) state <= WIN;
`endif
          end
        end
        SHUFFLE: begin
          if (steps == SW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            steps <= steps - SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_puzzle_ctrl.sv
// Self-checking bench for tile_puzzle_ctrl (2x2 board, 4-bit counter,
// 8-step shuffle). A board-level reference model applies moves by
// row/column arithmetic and predicts shuffles from the LFSR sequence.
module tb_tile_puzzle_ctrl;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam int STEPS = 8;
  localparam int N     = ROWS * COLS;
  localparam int PW    = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           btn_dir;
  logic                 btn_shuffle;
  logic [N*IDX_W-1:0]   tiles;
  logic [PW-1:0]        blank_pos;
  logic [CNT_W-1:0]     move_count;
  logic                 solved;
  logic                 busy;

  int          compares = 0;
  int          fails    = 0;
  int          mb [N];
  int          m_count;
  bit          m_win;
  int unsigned ncyc = 0;

  tile_puzzle_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .CNT_W(CNT_W), .SHUFFLE_STEPS(STEPS)
  ) dut (
    .clk(clk), .rst(rst), .btn_dir(btn_dir), .btn_shuffle(btn_shuffle),
    .tiles(tiles), .blank_pos(blank_pos), .move_count(move_count),
    .solved(solved), .busy(busy)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset edge; the LFSR has advanced this often.
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mb[i] = (i == N - 1) ? 0 : i + 1;
    m_count = 0;
    m_win   = 0;
  endfunction

  function automatic int model_blank();
    int b = 0;
    for (int i = 0; i < N; i++) if (mb[i] == 0) b = i;
    return b;
  endfunction

  function automatic bit model_home();
    bit h = 1;
    for (int i = 0; i < N; i++) if (mb[i] != ((i == N - 1) ? 0 : i + 1)) h = 0;
    return h;
  endfunction

  function automatic bit model_move(input int dir);
    int b = model_blank();
    int r = b / COLS;
    int c = b % COLS;
    int t;
    case (dir)
      0: r = r - 1;
      1: r = r + 1;
      2: c = c - 1;
      default: c = c + 1;
    endcase
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
    t     = r * COLS + c;
    mb[b] = mb[t];
    mb[t] = 0;
    return 1;
  endfunction

  function automatic logic [N*IDX_W-1:0] model_pack();
    logic [N*IDX_W-1:0] p = '0;
    for (int i = 0; i < N; i++) p[i*IDX_W +: IDX_W] = IDX_W'(mb[i]);
    return p;
  endfunction

  function automatic int unsigned lfsr_at(input int unsigned n);
    int unsigned l = 32'hACE1;
    int unsigned b;
    for (int unsigned k = 0; k < n; k++) begin
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
    return l;
  endfunction

  function automatic void model_press(input logic [3:0] bits);
    if (m_win) return;
    for (int d = 0; d < 4; d++) begin
      if (bits[d]) begin
        if (model_move(d)) begin
          if (m_count < (1 << CNT_W) - 1) m_count++;
`ifdef WIN_LOCK_EN
          if (model_home()) m_win = 1;
`endif
        end
        return;
      end
    end
  endfunction

  function automatic void model_shuffle(input int unsigned c0);
    for (int j = 0; j < STEPS; j++) begin
      void'(model_move(int'(lfsr_at(c0 + 3 + j) & 3)));
    end
    m_count = 0;
    m_win   = 0;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_tiles"}, 32'(tiles), 32'(model_pack()));
    checkValue({tag, "_blank"}, 32'(blank_pos), 32'(model_blank()));
    checkValue({tag, "_count"}, 32'(move_count), 32'(m_count));
    checkValue({tag, "_solved"}, 32'(solved), 32'(model_home()));
    checkValue({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkInvariant(input string tag);
    bit seen [N];
    bit ok = 1;
    int v;
    for (int i = 0; i < N; i++) seen[i] = 0;
    for (int i = 0; i < N; i++) begin
      v = int'(tiles[i*IDX_W +: IDX_W]);
      if (v >= N) ok = 0;
      else if (seen[v]) ok = 0;
      else seen[v] = 1;
    end
    v = int'(blank_pos);
    if (tiles[v*IDX_W +: IDX_W] !== '0) ok = 0;
    checkValue(tag, 32'(ok), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] bits, input logic shuf, input int hold);
    @(negedge clk);
    btn_dir     = bits;
    btn_shuffle = shuf;
    repeat (hold) @(negedge clk);
    btn_dir     = '0;
    btn_shuffle = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic doShuffle(input logic [3:0] same_dir, input bit abort);
    int unsigned c0;
    int          wait_n;
    int          busy_len;
    @(negedge clk);
    c0          = ncyc;
    btn_shuffle = 1'b1;
    btn_dir     = same_dir;
    @(negedge clk);
    btn_shuffle = 1'b0;
    btn_dir     = '0;
    wait_n = 0;
    while (busy !== 1'b1 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    checkValue("shuffle_busy_rise", 32'(busy), 32'd1);
    if (abort) begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      checkOutput("rst_in_shuffle");
      checkValue("rst_in_shuffle_lit", 32'(tiles), 32'h0D1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    busy_len = 0;
    while (busy === 1'b1 && busy_len < 100) begin
      busy_len++;
      if (busy_len == 2) begin
        btn_dir     = 4'($urandom_range(1, 15));
        btn_shuffle = 1'b1;
      end
      if (busy_len == 3) begin
        btn_dir     = '0;
        btn_shuffle = 1'b0;
      end
      @(negedge clk);
    end
    btn_dir     = '0;
    btn_shuffle = 1'b0;
    checkValue("shuffle_busy_len", 32'(busy_len), 32'(STEPS));
    repeat (4) @(negedge clk);
    model_shuffle(c0);
    checkOutput("after_shuffle");
    checkInvariant("shuffle_perm");
  endtask

  initial begin
    logic [3:0] bits;
    int         hold;
    rst         = 1'b1;
    btn_dir     = '0;
    btn_shuffle = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checkOutput("reset");
    checkValue("reset_lit", 32'(tiles), 32'h0D1);

    // Right from the bottom-right corner is off the board.
    applyStimulus(4'b1000, 1'b0, 1);
    model_press(4'b1000);
    checkOutput("right_edge");

    // Up+left held together: up wins, one move only, with exact latency.
    @(negedge clk);
    btn_dir = 4'b0101;
    @(posedge clk);
    @(posedge clk);
    #1 checkValue("uplft_early", 32'(tiles), 32'h0D1);
    @(posedge clk);
    #1 checkValue("uplft_tiles", 32'(tiles), 32'h4C1);
    checkValue("uplft_solved_old", 32'(solved), 32'd1);
    @(posedge clk);
    #1 checkValue("uplft_solved_new", 32'(solved), 32'd0);
    repeat (20) @(negedge clk);
    btn_dir = '0;
    repeat (4) @(negedge clk);
    model_press(4'b0101);
    checkOutput("uplft_held");

    applyStimulus(4'b0010, 1'b0, 2);
    model_press(4'b0010);
    checkOutput("down_home");
    checkValue("down_lit", 32'(tiles), 32'h0D1);

    applyStimulus(4'b0001, 1'b0, 1);
    model_press(4'b0001);
    checkOutput("up_after_solve");
`ifdef WIN_LOCK_EN
    checkValue("win_lock_lit", 32'(tiles), 32'h0D1);
`else
    checkValue("no_lock_lit", 32'(tiles), 32'h4C1);
`endif

    doShuffle(4'b0001, 1'b0);

    for (int i = 0; i < 30; i++) begin
      bits = 4'($urandom_range(1, 15));
      hold = int'($urandom_range(1, 4));
      applyStimulus(bits, 1'b0, hold);
      model_press(bits);
      checkOutput($sformatf("rand%0d", i));
    end

    doShuffle(4'b0000, 1'b0);
    doShuffle(4'b0000, 1'b1);

    for (int i = 0; i < 20; i++) begin
      bits = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      applyStimulus(bits, 1'b0, 1);
      model_press(bits);
    end
    checkOutput("saturate");
`ifndef WIN_LOCK_EN
    checkValue("saturate_lit", 32'(move_count), 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/tile_puzzle_ctrl.md
Name: tile_puzzle_ctrl

Overview:
Parametrised sliding-tile puzzle controller: the next generation of the game-control block behind the VGA tile renderer. It holds a ROWS x COLS board as a packed tile-index bus, so the VGA block can draw it directly. The board is driven by direction buttons and an LFSR-based shuffle, with a move counter and solved detection. It generalises the fixed 12-bit board to any grid size and adds sequenced shuffling, move counting and status outputs.

Parameters:
ROWS, 2, number of board rows (>=2)
COLS, 2, number of board columns (>=2)
IDX_W, 3, bits per cell; must satisfy 2**IDX_W >= ROWS*COLS
CNT_W, 16, move counter width
SHUFFLE_STEPS, 64, LFSR move attempts per shuffle (>=1)

Ports:
clk  input  1  system clock (single clock domain)
rst  input  1  synchronous, active-high reset
btn_dir  input  4  direction requests; [0]=up, [1]=down, [2]=left, [3]=right; level inputs from the debouncer, asynchronous to clk
btn_shuffle  input  1  shuffle request; level input, asynchronous
tiles  output  ROWS*COLS*IDX_W  packed board; cell i=r*COLS+c occupies bits [i*IDX_W +: IDX_W]; value 0 = blank
blank_pos  output  clog2(ROWS*COLS)  cell index of the blank
move_count  output  CNT_W  number of valid player moves since reset or last shuffle
solved  output  1  board equals the home arrangement
busy  output  1  shuffle in progress

Behaviour:
- Reset (rst high at a clk edge), which takes priority over everything: tiles = home arrangement (cell i holds i+1 for i<N-1; cell N-1 holds 0), blank_pos=N-1, move_count=0, solved=1, busy=0, state=IDLE, LFSR=16'hACE1, synchroniser/edge registers=0.
- Input path: each of the 5 buttons passes through a 2-FF synchroniser and then a rising-edge detector (pulse = s2 & ~s3).
  - An input first sampled high at edge k produces a one-cycle pulse, and its effect is registered at edge k+2.
  - A held button gives exactly one pulse.
- Move semantics: a direction moves the blank. Up: row-1. Down: row+1. Left: col-1. Right: col+1.
  - The neighbour tile is swapped into the old blank cell. The blank cell gets 0 and blank_pos updates at the same edge.
  - A move off the board edge is ignored: no change, no count.
  - Several direction pulses in one cycle: priority up > down > left > right; only one move is applied.
- move_count: increments by 1 per valid player move and saturates at all-ones. Shuffle moves are not counted.
- solved: registered compare of the board against the home arrangement. It updates one edge after any board change.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including in IDLE, so shuffle seeds depend on user timing.
- FSM:
  - IDLE: applies player moves. A btn_shuffle pulse enters SHUFFLE at the next edge, loads the step counter with SHUFFLE_STEPS, clears move_count to 0 and sets busy=1. A direction pulse in the same cycle as the shuffle pulse is discarded.
  - SHUFFLE: each cycle, LFSR[1:0] selects a direction (0 up, 1 down, 2 left, 3 right) and the move is applied if valid. An invalid move is skipped but still consumes a step.
  - After SHUFFLE_STEPS cycles, return to IDLE with busy=0. busy is high for exactly SHUFFLE_STEPS cycles.
  - Direction and shuffle pulses arriving during SHUFFLE are discarded, not queued.
- Reset during SHUFFLE: the board returns to home at that edge and busy=0.
- Invariant: tiles is always a permutation of 0..N-1, with exactly one 0, located at blank_pos.
- Board state lives in an N-entry register array; no RAM.

Optional Feature:
WIN_LOCK_EN
- Defined: when a player move makes the board solved, the controller enters a WIN state.
  - Direction pulses are ignored and move_count is frozen.
  - Only a shuffle pulse (to SHUFFLE) or rst leaves WIN.
  - The solved state produced by reset does not enter WIN.
- Undefined: no WIN state; moves are accepted while solved=1.

Test Plan:
- Reset, ROWS=COLS=2, IDX_W=3 -> tiles=12'h0D1, blank_pos=3, move_count=0, solved=1, busy=0.
- From reset, pulse up -> after 3 edges tiles=12'h4C1, blank_pos=1, move_count=1; solved=0 one edge later. Then pulse down -> tiles=12'h0D1, move_count=2, solved=1.
- From reset: pulse right (edge) -> no change, move_count=0. Then up+left held together -> only the up move applies: tiles=12'h4C1, and holding for 20 cycles gives no further moves.
- SHUFFLE_STEPS=8, pulse shuffle -> busy high for exactly 8 cycles, direction pulses during busy are ignored, move_count=0 afterwards, tiles is a permutation of {0,1,2,3} with the 0 at blank_pos. Assert rst at shuffle step 4 -> next edge tiles=12'h0D1, busy=0.
- CNT_W=4, 20 alternating up/down moves -> move_count saturates at 4'hF.
- With WIN_LOCK_EN: up then down -> solved=1 and subsequent up is ignored (tiles=12'h0D1, count=2); a shuffle pulse then restores normal moves. Without the macro, the same up is accepted (tiles=12'h4C1, count=3).
